// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory arbiter.
//   owner_t       : encoding of which requester owns the read data returning next cycle
//   ADDR_W/DATA_W : memory word address / data widths
//   VGA_BURST_DEF : default number of back-to-back VGA grants tolerated while the CPU waits
package mem_arb_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int VGA_BURST_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   inc        : count up by one unless already at max_val
//   clr        : synchronous clear, wins over inc
//   max_val    : saturation value
//   cnt        : current count
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < max_val)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the single-port, synchronous-read main memory.
// VGA has priority, but after VGA_BURST consecutive VGA wins against a waiting
// CPU the CPU is granted. Read data returns one cycle after the grant and is
// flagged to the requester that issued the read.
//   clk, rst_n                               : clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata                    : CPU access request
//   cpu_gnt, cpu_rvalid, cpu_rdata           : CPU grant and read response
//   vga_req/addr                             : VGA read request
//   vga_gnt, vga_rvalid, vga_rdata           : VGA grant and read response
//   mem_addr/we/wdata, mem_rdata             : memory primitive port
//   cpu_wait_cnt                             : saturating count of CPU lost cycles
//
// rd_owner | meaning
// ---------+-----------------------------------------------
// NONE     | no read issued last cycle, mem_rdata unowned
// CPU      | CPU read issued last cycle, data for the CPU
// VGA      | VGA read issued last cycle, data for the VGA
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int VGA_BURST = VGA_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       cpu_wait_cnt
);

    localparam logic [3:0] BURST_MAX = 4'(VGA_BURST);

    logic [3:0] burst_cnt;
    owner_t     rd_owner;
    owner_t     rd_owner_nxt;
    logic       vga_wins;

    // Grants are gated by rst_n so requests are ignored while reset is held.
    assign vga_wins = vga_req && (!cpu_req || (burst_cnt < BURST_MAX));
    assign vga_gnt  = rst_n && vga_wins;
    assign cpu_gnt  = rst_n && cpu_req && !vga_wins;

    // Burst limit only applies while the CPU is actually waiting.
    sat_counter #(.WIDTH(4)) u_burst_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (vga_gnt && cpu_req),
        .clr     (cpu_gnt || !cpu_req),
        .max_val (BURST_MAX),
        .cnt     (burst_cnt)
    );

    sat_counter #(.WIDTH(16)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (cpu_req && !cpu_gnt),
        .clr     (1'b0),
        .max_val (16'hFFFF),
        .cnt     (cpu_wait_cnt)
    );

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (vga_gnt) begin
            mem_addr  = vga_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= rd_owner_nxt;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (cpu_gnt && !cpu_we) begin
            rd_owner_nxt = OWN_CPU;
        end else if (vga_gnt) begin
            rd_owner_nxt = OWN_VGA;
        end
    end

    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign vga_rvalid = (rd_owner == OWN_VGA);
    assign cpu_rdata  = mem_rdata;
    assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic        vga_gnt, vga_rvalid;
    logic [15:0] vga_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [15:0] cpu_wait_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.VGA_BURST(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_gnt      (cpu_gnt),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .vga_req      (vga_req),
        .vga_addr     (vga_addr),
        .vga_gnt      (vga_gnt),
        .vga_rvalid   (vga_rvalid),
        .vga_rdata    (vga_rdata),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .cpu_wait_cnt (cpu_wait_cnt)
    );

    // Memory model: location 0x0040 is real storage, every other address
    // returns a fixed pattern derived from the address.
    logic [15:0] loc_40;
    always @(posedge clk) begin
        if (mem_we && mem_addr == 16'h0040) loc_40 <= mem_wdata;
        mem_rdata <= (mem_addr == 16'h0040) ? loc_40 : (mem_addr ^ 16'h5A5A);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        vga_req = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] cpu_pat;
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 16'h0;
        vga_req   = 1'b1;
        vga_addr  = 16'h8000;

        // Reset: requests ignored, all outputs quiet
        #2;
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_vga_gnt", vga_gnt, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        cyc();
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_vga_rvalid", vga_rvalid, 0);
        chk("rst_wait_cnt", cpu_wait_cnt, 0);
        cpu_req = 1'b0;
        vga_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        // CPU write then read of 0x0040
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
        #2;
        chk("wr_cpu_gnt", cpu_gnt, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 16'h0040);
        chk("wr_mem_wdata", mem_wdata, 16'hBEEF);
        cyc();
        cpu_we = 1'b0;
        #2;
        chk("wr_no_rvalid", cpu_rvalid, 0);
        chk("rd_cpu_gnt", cpu_gnt, 1);
        chk("rd_mem_we", mem_we, 0);
        cyc();
        cpu_req = 1'b0;
        #2;
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
        chk("rd_vga_rvalid", vga_rvalid, 0);
        chk("rd_mem_idle_addr", mem_addr, 0);
        cyc();
        chk("rd_rvalid_pulse", cpu_rvalid, 0);

        // VGA streaming 0x8000..0x8007, CPU idle
        for (int i = 0; i <= 8; i++) begin
            vga_req  = (i < 8);
            vga_addr = 16'h8000 + 16'(i);
            #2;
            if (i < 8) begin
                chk("vga_gnt", vga_gnt, 1);
                chk("vga_mem_addr", mem_addr, 16'h8000 + 16'(i));
            end else begin
                chk("vga_gnt_end", vga_gnt, 0);
            end
            if (i > 0) begin
                chk("vga_rvalid", vga_rvalid, 1);
                chk("vga_rdata", vga_rdata, (16'h8000 + 16'(i - 1)) ^ 16'h5A5A);
            end else begin
                chk("vga_rvalid_first", vga_rvalid, 0);
            end
            chk("vga_cpu_rvalid", cpu_rvalid, 0);
            cyc();
        end
        chk("vga_rvalid_done", vga_rvalid, 0);
        chk("vga_wait_cnt", cpu_wait_cnt, 0);

        // Contention with VGA_BURST=4: V,V,V,V,C,V,V,V,V,C
        cpu_pat = 10'b10_0001_0000;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        vga_req = 1'b1; vga_addr = 16'h8100;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("cont_cpu_gnt", cpu_gnt, cpu_pat[i]);
            chk("cont_vga_gnt", vga_gnt, !cpu_pat[i]);
            if (i > 0) begin
                chk("cont_cpu_rvalid", cpu_rvalid, cpu_pat[i-1]);
                chk("cont_vga_rvalid", vga_rvalid, !cpu_pat[i-1]);
            end
            cyc();
        end
        cpu_req = 1'b0; vga_req = 1'b0;
        #2;
        chk("cont_wait_cnt", cpu_wait_cnt, 8);
        chk("cont_last_rdata", cpu_rdata, 16'hBEEF);
        cyc();

        // CPU withdraws after two lost cycles
        do_reset();
        cpu_req = 1'b1; vga_req = 1'b1; vga_addr = 16'h8200;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("wd_vga_gnt", vga_gnt, 1);
            chk("wd_cpu_gnt", cpu_gnt, 0);
            cyc();
        end
        chk("wd_burst_before", dut.burst_cnt, 2);
        cpu_req = 1'b0;
        #2;
        chk("wd_cpu_gnt_off", cpu_gnt, 0);
        cyc();
        chk("wd_burst_clear", dut.burst_cnt, 0);
        chk("wd_wait_cnt", cpu_wait_cnt, 2);
        chk("wd_cpu_rvalid", cpu_rvalid, 0);
        // Re-request: cleared burst means a full four VGA grants first
        cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("wd_rereq_cpu_gnt", cpu_gnt, (i == 4));
            chk("wd_no_spurious", cpu_rvalid, 0);
            cyc();
        end
        chk("wd_rereq_rvalid", cpu_rvalid, 1);
        chk("wd_wait_cnt2", cpu_wait_cnt, 6);
        cpu_req = 1'b0; vga_req = 1'b0;
        cyc();

        // Reset falls in the cycle a VGA read is granted
        vga_req = 1'b1; vga_addr = 16'h8003;
        #2;
        chk("rr_vga_gnt", vga_gnt, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_gnt_in_reset", vga_gnt, 0);
        cyc();
        chk("rr_vga_rvalid", vga_rvalid, 0);
        vga_req = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rr_vga_rvalid_post", vga_rvalid, 0);
        chk("rr_wait_cnt", cpu_wait_cnt, 0);
        chk("rr_burst_cnt", dut.burst_cnt, 0);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040;
        #1;
        chk("rr_first_gnt", cpu_gnt, 1);
        cyc();
        cpu_req = 1'b0;
        #1;
        chk("rr_first_rvalid", cpu_rvalid, 1);
        chk("rr_first_rdata", cpu_rdata, 16'hBEEF);
        cyc();

        // cpu_wait_cnt saturation: CPU loses 4 of every 5 cycles,
        // 82000 cycles gives 65600 lost cycles, past 0xFFFF
        do_reset();
        cpu_req = 1'b1; vga_req = 1'b1; vga_addr = 16'h8000;
        for (int i = 0; i < 82000; i++) cyc();
        chk("sat_wait_cnt", cpu_wait_cnt, 16'hFFFF);
        for (int i = 0; i < 100; i++) cyc();
        chk("sat_no_wrap", cpu_wait_cnt, 16'hFFFF);
        cpu_req = 1'b0; vga_req = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the single-port, synchronous-read main memory between two requesters: the CPU datapath (read/write) and the VGA row fetcher (read-only).
- Issues at most one access per cycle. Steers the one-cycle-late read data back to whichever requester issued the read.
- Gives VGA priority for display deadlines, but bounds CPU starvation with a burst limit.
- Sits between the CPU's memory port, the VGA fetcher and the memory primitive.

## Interface
Parameters:
- VGA_BURST, 4, max consecutive VGA grants while CPU is requesting; range 1..15.

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; 0 clears all state
- cpu_req  in  1  CPU access request; held until granted or withdrawn
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  16  CPU word address
- cpu_wdata  in  16  CPU write data
- cpu_gnt  out  1  access issued this cycle
- cpu_rvalid  out  1  cpu_rdata valid this cycle
- cpu_rdata  out  16  read data
- vga_req  in  1  VGA read request
- vga_addr  in  16  VGA word address
- vga_gnt  out  1  read issued this cycle
- vga_rvalid  out  1  vga_rdata valid this cycle
- vga_rdata  out  16  read data
- mem_addr  out  16  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data; valid the cycle after the address
- cpu_wait_cnt  out  16  saturating count of cycles cpu_req=1 and cpu_gnt=0

## Operation
Grant decision is combinational from current requests plus registered state. There are no wait states on an idle bus.

Arbitration:
- Only cpu_req: cpu_gnt=1.
- Only vga_req: vga_gnt=1.
- Both, with burst_cnt < VGA_BURST: vga_gnt=1.
- Both, with burst_cnt == VGA_BURST: cpu_gnt=1.
- cpu_gnt and vga_gnt are never both 1.

burst_cnt (4-bit register):
- Increments on a VGA grant while cpu_req=1. Saturates at VGA_BURST.
- Clears on any CPU grant.
- Clears on any cycle cpu_req=0, so VGA is unlimited when the CPU is idle.

Memory drive:
- On CPU grant: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
- On VGA grant: mem_addr=vga_addr, mem_we=0.
- No grant: mem_addr=0, mem_we=0, mem_wdata=0.

Response steering uses a registered owner, rd_owner ∈ {NONE, CPU, VGA}:
- Next value is CPU on a CPU read grant, VGA on a VGA grant, NONE otherwise. CPU writes give NONE.
- cpu_rvalid = (rd_owner==CPU). vga_rvalid = (rd_owner==VGA).
- cpu_rdata and vga_rdata are both wired to mem_rdata. Consumers qualify with rvalid.

Other rules:
- Requesters may withdraw a request before grant with no side effect.
- cpu_wait_cnt increments each cycle cpu_req=1 and cpu_gnt=0. It saturates at 0xFFFF and clears only on Reset.

## Timing
- Grant latency is 0 cycles: request in cycle N, grant in N if won.
- Read data: rvalid and data in cycle N+1 for a read granted in N.
- Back-to-back reads: one read per cycle sustained. rvalid is a one-cycle pulse per grant.
- Worst CPU wait under continuous vga_req: VGA_BURST cycles. The CPU is granted in cycle VGA_BURST after it starts requesting, counting from 0.
- Reset=0, asynchronous:
  - rd_owner=NONE, burst_cnt=0, cpu_wait_cnt=0.
  - All gnt/rvalid outputs 0, mem_we=0, mem_addr=0.
  - Requests are ignored while Reset=0.
- Reset mid-read: a read granted in the cycle Reset falls produces no rvalid.
- Simultaneous arrival of both requests with burst_cnt=0: VGA wins.

## Structure
- Shared package mem_arb_pkg holds:
  - owner encoding: OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_VGA=2'd2
  - ADDR_W=16, DATA_W=16
  - default VGA_BURST
- One natural sub-module: sat_counter, parameterised width, with inc, clr and saturate. Instantiate it for burst_cnt (4 bits, max VGA_BURST) and cpu_wait_cnt (16 bits).
- Grant logic and memory mux stay inline.

## Test plan
- CPU alone:
  - Write 0xBEEF to 0x0040: cpu_gnt=1 same cycle, mem_we=1, mem_addr=0x0040, no rvalid next cycle.
  - Then read 0x0040: cpu_rvalid=1 next cycle with cpu_rdata=0xBEEF.
- VGA streaming 0x8000..0x8007 every cycle, CPU idle: 8 consecutive vga_gnt, vga_rvalid pulses lag by 1 cycle, cpu_wait_cnt stays 0.
- Contention, VGA_BURST=4, both requesting continuously from cycle 0:
  - Grant pattern V,V,V,V,C,V,V,V,V,C.
  - cpu_wait_cnt=8 after 10 cycles.
- CPU withdraws cpu_req after 2 lost cycles: burst_cnt clears, cpu_wait_cnt=2, no cpu_gnt, no spurious rvalid.
- Reset asserted the cycle a VGA read is granted: vga_rvalid stays 0, all counters read 0 after release, first post-reset request is granted immediately.
- cpu_req held against continuous VGA for 0x20000 cycles: cpu_wait_cnt saturates at 0xFFFF and does not wrap.
